// File: rtl/ping_request.sv
// ICMP echo-request generator: streams header, id/seq word and a seeded byte-ramp
// payload as 32-bit words, with the Internet checksum computed before word 0 leaves.
module ping_request #(
    parameter int unsigned PAYLOAD_WORDS = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [15:0] i_id,
    input  logic [15:0] i_seq,
    input  logic [7:0]  i_seed,
    output logic [31:0] o_data,
    output logic        o_valid,
    input  logic        i_rdy,
    output logic        o_eop,
    output logic [7:0]  o_word_count,
    output logic        o_busy
);

    localparam logic [7:0] CALC_LAST = 8'(PAYLOAD_WORDS);
    localparam logic [7:0] LAST_IDX  = 8'(PAYLOAD_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FOLD,
        S_SEND
    } state_t;

    state_t      state_q;
    logic [15:0] id_q;
    logic [15:0] seq_q;
    logic [7:0]  seed_q;
    logic [31:0] acc_q;
    logic [7:0]  idx_q;

    logic [7:0]  idx_d;
    logic [7:0]  base_d;
    logic [7:0]  b0_d, b1_d, b2_d, b3_d;
    logic [31:0] word_d;
    logic [16:0] word_sum_d;
    logic [16:0] fold1_d;
    logic [15:0] fold2_d;

    assign o_word_count = 8'(PAYLOAD_WORDS + 2);

    // word_d is message word idx_q+1: the next word to sum in CALC and the next
    // word to present in SEND, so one generator serves both states.
    always_comb begin
        idx_d      = idx_q + 8'd1;
        base_d     = (idx_q - 8'd1) << 2;
        b0_d       = base_d + seed_q;
        b1_d       = b0_d + 8'd1;
        b2_d       = b0_d + 8'd2;
        b3_d       = b0_d + 8'd3;
        word_d     = (idx_q == 8'd0) ? {id_q, seq_q} : {b0_d, b1_d, b2_d, b3_d};
        word_sum_d = {1'b0, word_d[31:16]} + {1'b0, word_d[15:0]};
        fold1_d    = {1'b0, acc_q[31:16]} + {1'b0, acc_q[15:0]};
        fold2_d    = fold1_d[15:0] + {15'b0, fold1_d[16]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            seq_q   <= '0;
            seed_q  <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_eop   <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        id_q    <= i_id;
                        seq_q   <= i_seq;
                        seed_q  <= i_seed;
                        acc_q   <= 32'h0000_0800;
                        idx_q   <= '0;
                        o_busy  <= 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_q + {15'b0, word_sum_d};
                    idx_q <= idx_d;
                    if (idx_q == CALC_LAST) begin
                        state_q <= S_FOLD;
                    end
                end
                S_FOLD: begin
                    o_data  <= {8'd8, 8'd0, ~fold2_d};
                    o_valid <= 1'b1;
                    o_eop   <= 1'b0;
                    idx_q   <= '0;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (i_rdy) begin
                        if (idx_q == LAST_IDX) begin
                            o_data  <= '0;
                            o_valid <= 1'b0;
                            o_eop   <= 1'b0;
                            o_busy  <= 1'b0;
                            idx_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q  <= idx_d;
                            o_data <= word_d;
                            o_eop  <= (idx_d == LAST_IDX);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ping_request.sv
// Directed bench for ping_request: hand-computed P=1 messages plus a P=80 byte-wrap run.
module tb_ping_request;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_start, a_rdy, a_valid, a_eop, a_busy;
    logic [15:0] a_id, a_seq;
    logic [7:0]  a_seed, a_wc;
    logic [31:0] a_data;
    logic        b_start, b_rdy, b_valid, b_eop, b_busy;
    logic [15:0] b_id, b_seq;
    logic [7:0]  b_seed, b_wc;
    logic [31:0] b_data;

    ping_request #(.PAYLOAD_WORDS(1)) u_p1 (
        .clk(clk), .rst(rst), .i_start(a_start), .i_id(a_id), .i_seq(a_seq),
        .i_seed(a_seed), .o_data(a_data), .o_valid(a_valid), .i_rdy(a_rdy),
        .o_eop(a_eop), .o_word_count(a_wc), .o_busy(a_busy)
    );

    ping_request #(.PAYLOAD_WORDS(80)) u_p80 (
        .clk(clk), .rst(rst), .i_start(b_start), .i_id(b_id), .i_seq(b_seq),
        .i_seed(b_seed), .o_data(b_data), .o_valid(b_valid), .i_rdy(b_rdy),
        .o_eop(b_eop), .o_word_count(b_wc), .o_busy(b_busy)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] a_cap [0:7];
    int          a_n, a_eops;
    logic [31:0] b_cap [0:127];
    int          b_n, b_eops;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_a(input logic [15:0] id, input logic [15:0] seq, input logic [7:0] seed);
        a_id    = id;
        a_seq   = seq;
        a_seed  = seed;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    // Collects one message from the P=1 instance; optionally randomises i_rdy and
    // pulses i_start (with a foreign seq) during CALC and SEND.
    task automatic collect_a(input bit rand_rdy, input bit poke);
        bit          done = 1'b0;
        bit          prev_hold = 1'b0;
        logic [31:0] prev_data = '0;
        a_n    = 0;
        a_eops = 0;
        for (int c = 1; c <= 200 && !done; c++) begin
            a_start = poke && (c == 1 || c == 4);
            if (poke) a_seq = 16'hBEEF;
            if (prev_hold) begin
                chk("hold_valid", {31'b0, a_valid}, 32'd1);
                chk("hold_data", a_data, prev_data);
            end
            a_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (a_valid && a_rdy) begin
                if (a_n < 8) a_cap[a_n] = a_data;
                a_n++;
                if (a_eop) begin
                    a_eops++;
                    done = 1'b1;
                end
            end
            prev_hold = a_valid && !a_rdy;
            prev_data = a_data;
            tick();
        end
        a_start = 1'b0;
        a_rdy   = 1'b1;
        chk("a_complete", {31'b0, done}, 32'd1);
        chk("a_idle_busy", {31'b0, a_busy}, 32'd0);
        chk("a_idle_valid", {31'b0, a_valid}, 32'd0);
    endtask

    task automatic check_a(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2);
        chk({tag, "_count"}, 32'(a_n), 32'd3);
        chk({tag, "_eops"}, 32'(a_eops), 32'd1);
        chk({tag, "_w0"}, a_cap[0], w0);
        chk({tag, "_w1"}, a_cap[1], w1);
        chk({tag, "_w2"}, a_cap[2], w2);
    endtask

    function automatic logic [31:0] pat(input int k, input logic [7:0] seed);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) begin
            w[31 - 8*j -: 8] = 8'((4*k + j + int'(seed)) % 256);
        end
        return w;
    endfunction

    initial begin
        logic [31:0] s, w, ref_hdr;
        int          bad;
        bit          b_done;

        rst = 1'b1;
        a_start = 1'b0; a_rdy = 1'b1; a_id = '0; a_seq = '0; a_seed = '0;
        b_start = 1'b0; b_rdy = 1'b1; b_id = '0; b_seq = '0; b_seed = '0;
        tick();
        tick();

        chk("rst_valid", {31'b0, a_valid}, 32'd0);
        chk("rst_eop", {31'b0, a_eop}, 32'd0);
        chk("rst_busy", {31'b0, a_busy}, 32'd0);
        chk("rst_data", a_data, 32'd0);
        chk("rst_wc_p1", {24'b0, a_wc}, 32'd3);
        chk("rst_wc_p80", {24'b0, b_wc}, 32'd82);
        chk("rst_b_busy", {31'b0, b_busy}, 32'd0);
        rst = 1'b0;
        tick();

        // P=1 basic message with latency check: valid first high in cycle 4
        start_a(16'h1234, 16'h0001, 8'h00);
        chk("t1_busy_c1", {31'b0, a_busy}, 32'd1);
        chk("t1_valid_c1", {31'b0, a_valid}, 32'd0);
        tick();
        chk("t1_valid_c2", {31'b0, a_valid}, 32'd0);
        tick();
        chk("t1_valid_c3", {31'b0, a_valid}, 32'd0);
        tick();
        chk("t1_valid_c4", {31'b0, a_valid}, 32'd1);
        chk("t1_eop_c4", {31'b0, a_eop}, 32'd0);
        collect_a(1'b0, 1'b0);
        check_a("t1", 32'h0800E3C6, 32'h12340001, 32'h00010203);

        // Carry-heavy checksum, started in the first idle cycle
        start_a(16'hFFFF, 16'hFFFF, 8'hFC);
        chk("t2_busy", {31'b0, a_busy}, 32'd1);
        collect_a(1'b0, 1'b0);
        check_a("t2", 32'h0800FC01, 32'hFFFFFFFF, 32'hFCFDFEFF);

        // Random backpressure
        start_a(16'h1234, 16'h0001, 8'h00);
        collect_a(1'b1, 1'b0);
        check_a("t3", 32'h0800E3C6, 32'h12340001, 32'h00010203);

        // Start pulses during CALC and SEND are ignored
        start_a(16'h1234, 16'h0001, 8'h00);
        collect_a(1'b0, 1'b1);
        check_a("t4", 32'h0800E3C6, 32'h12340001, 32'h00010203);
        start_a(16'hFFFF, 16'hFFFF, 8'hFC);
        chk("t4_restart_busy", {31'b0, a_busy}, 32'd1);
        collect_a(1'b0, 1'b0);
        check_a("t4b", 32'h0800FC01, 32'hFFFFFFFF, 32'hFCFDFEFF);

        // Reset mid-SEND, then a clean message
        start_a(16'h1234, 16'h0001, 8'h00);
        tick(); tick(); tick();
        chk("t5_valid_pre", {31'b0, a_valid}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_valid", {31'b0, a_valid}, 32'd0);
        chk("t5_rst_busy", {31'b0, a_busy}, 32'd0);
        chk("t5_rst_eop", {31'b0, a_eop}, 32'd0);
        start_a(16'hFFFF, 16'hFFFF, 8'hFC);
        collect_a(1'b0, 1'b0);
        check_a("t5", 32'h0800FC01, 32'hFFFFFFFF, 32'hFCFDFEFF);

        // P=80 run with byte wrap in the payload
        b_id = 16'hABCD; b_seq = 16'h0042; b_seed = 8'h10;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_n = 0; b_eops = 0; b_done = 1'b0;
        for (int c = 0; c < 400 && !b_done; c++) begin
            if (b_valid) begin
                if (b_n < 128) b_cap[b_n] = b_data;
                b_n++;
                if (b_eop) begin
                    b_eops++;
                    b_done = 1'b1;
                end
            end
            tick();
        end
        chk("p80_complete", {31'b0, b_done}, 32'd1);
        chk("p80_count", 32'(b_n), 32'd82);
        chk("p80_eops", 32'(b_eops), 32'd1);
        chk("p80_pay59", b_cap[61], 32'hFCFDFEFF);
        chk("p80_pay60", b_cap[62], 32'h00010203);
        chk("p80_idseq", b_cap[1], 32'hABCD0042);

        s = 32'h0800 + 32'hABCD + 32'h0042;
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            w = pat(k, 8'h10);
            s = s + (w >> 16) + (w & 32'h0000FFFF);
            if (b_cap[k + 2] !== w) bad++;
        end
        while ((s >> 16) != 0) s = (s & 32'h0000FFFF) + (s >> 16);
        ref_hdr = {16'h0800, ~s[15:0]};
        chk("p80_header", b_cap[0], ref_hdr);
        chk("p80_payload_bad", 32'(bad), 32'd0);
        chk("p80_idle_busy", {31'b0, b_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ping_request.md
# ping_request

Initiator side of the ICMP echo exchange. It builds a complete ICMP echo-request message (type 8) as a stream of 32-bit words: header, identifier/sequence word, then a generated byte-pattern payload. It computes the Internet checksum before the first word leaves and emits the words over a valid/ready handshake. The stream goes to the IP/UDP framing stage of the Ethernet transmit path, and the echo reply comes back through the existing receive-side payload logic.

## Interface
- PAYLOAD_WORDS, default 14, number of 32-bit payload words P (56 bytes); legal range 1..253.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  request a new message; sampled only in IDLE.
- i_id  in  16  ICMP identifier; latched on an accepted start.
- i_seq  in  16  ICMP sequence number; latched on an accepted start.
- i_seed  in  8  payload pattern seed; latched on an accepted start.
- o_data  out  32  current message word, MSB-first byte order.
- o_valid  out  1  o_data is valid.
- i_rdy  in  1  sink accepts o_data this cycle when o_valid=1.
- o_eop  out  1  high with the last word (o_valid=1).
- o_word_count  out  8  message length in words, constant P+2.
- o_busy  out  1  high in any state other than IDLE.

## Operation
- Message layout:
  - Word 0 = {8'd8, 8'd0, checksum}.
  - Word 1 = {id, seq}.
  - Words 2..P+1 carry payload word k = {B(4k), B(4k+1), B(4k+2), B(4k+3)}, where B(n) = (n + seed) mod 256. Bytes wrap modulo 256.
- States: IDLE, CALC, FOLD, SEND.
- IDLE: when i_start=1, latch id/seq/seed, load the 32-bit accumulator with 32'h0000_0800 (the type/code half-word), clear the word index, and go to CALC.
- CALC: one word per cycle. Word 1 first, then payload words 0..P-1. Each cycle, acc += word[31:16] + word[15:0]. After P+1 words, go to FOLD.
- FOLD: s1 = acc[31:16] + acc[15:0]; s2 = s1[31:16] + s1[15:0]; checksum = ~s2[15:0]. Register the checksum and go to SEND with the word index at 0.
- SEND:
  - Assert o_valid and present the word at the current index.
  - The index advances only when o_valid && i_rdy.
  - o_eop = (index == P+1).
  - A handshake on the last word returns the block to IDLE.
- Payload words are generated arithmetically in both CALC and SEND; no memory is used.
- i_start outside IDLE is ignored; it does not alter the latched fields.
- i_rdy while o_valid=0 has no effect.
- Reset at any point returns the block to IDLE. An in-flight message is discarded, not resumed.

## Timing
- Reset values:
  - o_valid=0, o_eop=0, o_busy=0, o_data=0.
  - Accumulator and index are 0.
  - o_word_count is always P+2.
- Start accepted in cycle 0:
  - CALC occupies cycles 1..P+1.
  - FOLD occupies cycle P+2.
  - o_valid first rises in cycle P+3 with word 0.
- o_busy rises in cycle 1 and falls the cycle after the final handshake.
- With i_rdy held high, one word is emitted per cycle. A message then spans P+2 cycles, and the block is back in IDLE the cycle after the last word.
- o_data, o_valid and o_eop are registered outputs or decode from registered state only; there is no combinational path from i_rdy.
- A start can be accepted in the first cycle the block is back in IDLE; there are no dead cycles.

## Test plan
- P=1, id=0x1234, seq=0x0001, seed=0x00, rdy=1 -> words 0x0800E3C6, 0x12340001, 0x00010203. o_eop on the third word; o_valid first high 4 cycles after start.
- P=1, id=0xFFFF, seq=0xFFFF, seed=0xFC -> acc=0x000403FA, fold 0x03FE, words 0x0800FC01, 0xFFFFFFFF, 0xFCFDFEFF.
- P=80, seed=0x10 -> payload word 59 = 0xFCFDFEFF, word 60 = 0x00010203 (byte wrap). Checksum matches a reference model; exactly 82 words, one eop.
- Random i_rdy backpressure (~50%) -> stream identical to the rdy=1 run, no word skipped or duplicated, o_data stable while o_valid && !i_rdy.
- i_start pulsed during CALC and SEND with different seq -> ignored; output seq unchanged; the next start after return to IDLE is accepted the same cycle.
- rst asserted mid-SEND -> next cycle o_valid=0, o_busy=0. A new start yields a full, correct message starting at word 0.
